// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and bit-mixing helpers for the
// single-block SHA-256 engine.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr32(x, 5'd2) ^ rotr32(x, 5'd13) ^ rotr32(x, 5'd22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr32(x, 5'd6) ^ rotr32(x, 5'd11) ^ rotr32(x, 5'd25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr32(x, 5'd7) ^ rotr32(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr32(x, 5'd17) ^ rotr32(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Sliding 16-word message schedule: word 0 of the window is W[t] for the
// current round, and each shift appends W[t+16].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [511:0] block,
    output logic [31:0]  w
);

    logic [31:0] win_r [0:15];
    logic [31:0] next_w_s;

    // Expansion of the word sixteen rounds ahead of the current one
    always_comb begin
        next_w_s = ssig1(win_r[14]) + win_r[9] + ssig0(win_r[1]) + win_r[0];
    end

    // Window register: clear, load block big-endian, or shift by one word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) win_r[i] <= 32'd0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win_r[i] <= block[511 - 32*i -: 32];
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
            win_r[15] <= next_w_s;
        end
    end

    assign w = win_r[0];

endmodule

// File: rtl/sha256_block_core.sv
// Single-block SHA-256 compression from the standard IV; 66 cycles from
// reset release to a sticky ready with the digest held in hashvalue.
module sha256_block_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] message,
    output logic         ready,
    output logic [255:0] hashvalue
);

    state_e      state_r, next_state_s;
    logic [5:0]  t_r;
    logic [31:0] wv_r [0:7];
    logic [31:0] w_s, t1_s, t2_s;
    logic        load_s, shift_s;

    sha256_msg_sched u_sched (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .shift_en (shift_s),
        .block    (message),
        .w        (w_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_LOAD;
        else       state_r <= next_state_s;
    end

    // Next-state and schedule control
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            ST_LOAD: begin
                load_s       = 1'b1;
                next_state_s = ST_ROUND;
            end
            ST_ROUND: begin
                shift_s = 1'b1;
                if (t_r == 6'd63) next_state_s = ST_FINAL;
                else              next_state_s = ST_ROUND;
            end
            ST_FINAL: next_state_s = ST_DONE;
            ST_DONE:  next_state_s = ST_DONE;
            default:  next_state_s = ST_LOAD;
        endcase
    end

    // Round temporaries T1/T2 for the current t
    always_comb begin
        t1_s = wv_r[7] + bsig1(wv_r[4]) + ch(wv_r[4], wv_r[5], wv_r[6]) + K[t_r] + w_s;
        t2_s = bsig0(wv_r[0]) + maj(wv_r[0], wv_r[1], wv_r[2]);
    end

    // Working variables, round counter and registered digest/ready
    always_ff @(posedge clk) begin
        if (reset) begin
            t_r       <= 6'd0;
            ready     <= 1'b0;
            hashvalue <= 256'd0;
            for (int i = 0; i < 8; i++) wv_r[i] <= 32'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    t_r <= 6'd0;
                    for (int i = 0; i < 8; i++) wv_r[i] <= IV[i];
                end
                ST_ROUND: begin
                    wv_r[0] <= t1_s + t2_s;
                    wv_r[1] <= wv_r[0];
                    wv_r[2] <= wv_r[1];
                    wv_r[3] <= wv_r[2];
                    wv_r[4] <= wv_r[3] + t1_s;
                    wv_r[5] <= wv_r[4];
                    wv_r[6] <= wv_r[5];
                    wv_r[7] <= wv_r[6];
                    t_r     <= t_r + 6'd1;
                end
                ST_FINAL: begin
                    hashvalue <= {IV[0] + wv_r[0], IV[1] + wv_r[1], IV[2] + wv_r[2], IV[3] + wv_r[3],
                                  IV[4] + wv_r[4], IV[5] + wv_r[5], IV[6] + wv_r[6], IV[7] + wv_r[7]};
                    ready     <= 1'b1;
                end
                ST_DONE: begin
                    ready <= 1'b1;
                end
                default: begin
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_core.sv
// Self-checking bench for sha256_block_core: known-answer digests, latency,
// stability, message-isolation, mid-run reset and random blocks vs a model.
module tb_sha256_block_core;

    logic         clk;
    logic         reset;
    logic [511:0] message;
    logic         ready;
    logic [255:0] hashvalue;

    int checks   = 0;
    int failures = 0;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_block_core dut (
        .clk       (clk),
        .reset     (reset),
        .message   (message),
        .ready     (ready),
        .hashvalue (hashvalue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression of one block with a fully expanded schedule
    function automatic logic [255:0] sha256_ref(input logic [511:0] blk);
        logic [31:0]  w [0:63];
        logic [31:0]  v [0:7];
        logic [31:0]  s0, s1, t1, t2;
        logic [255:0] dig;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = H0[i];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) dig[255 - 32*i -: 32] = H0[i] + v[i];
        return dig;
    endfunction

    // Hold reset for n edges; outputs must be cleared after each one
    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0 || hashvalue !== 256'd0) begin
                failures++;
                $display("FAIL reset_clear: ready=%b hash=%h want ready=0 hash=0", ready, hashvalue);
            end
        end
    endtask

    // Release reset, optionally swap message after edge switch_at, and check
    // latency, idle outputs before completion and the final digest.
    task automatic run_to_ready(input string name, input logic [255:0] exp,
                                input int switch_at, input logic [511:0] new_msg);
        int edges;
        edges = 0;
        reset = 1'b0;
        while (ready !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (edges == switch_at) message = new_msg;
            if (ready !== 1'b1) begin
                checks++;
                if (hashvalue !== 256'd0 || ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy: edge %0d ready=%b hash=%h want ready=0 hash=0", name, edges, ready, hashvalue);
                end
            end
        end
        checks++;
        if (edges != 66) begin
            failures++;
            $display("FAIL %s_latency: ready after %0d edges want 66", name, edges);
        end
        checks++;
        if (hashvalue !== exp) begin
            failures++;
            $display("FAIL %s_digest: got %h want %h", name, hashvalue, exp);
        end
    endtask

    task automatic test_reset();
        message = ABC_BLK;
        apply_reset(10);
    endtask

    task automatic test_abc();
        run_to_ready("abc", ABC_DIG, -1, 512'd0);
    endtask

    task automatic test_stability();
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 16; j++) message[511 - 32*j -: 32] = $urandom;
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b1 || hashvalue !== ABC_DIG) begin
                failures++;
                $display("FAIL stability: cycle %0d ready=%b hash=%h want ready=1 hash=%h", i, ready, hashvalue, ABC_DIG);
            end
        end
    endtask

    task automatic test_empty();
        apply_reset(2);
        message = EMPTY_BLK;
        run_to_ready("empty", EMPTY_DIG, -1, 512'd0);
    endtask

    task automatic test_msg_change();
        apply_reset(1);
        message = ABC_BLK;
        run_to_ready("msg_change", ABC_DIG, 11, EMPTY_BLK);
    endtask

    task automatic test_reset_mid();
        apply_reset(1);
        message = ABC_BLK;
        reset   = 1'b0;
        for (int i = 0; i < 31; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0 || hashvalue !== 256'd0) begin
                failures++;
                $display("FAIL midrun_busy: edge %0d ready=%b hash=%h want 0", i + 1, ready, hashvalue);
            end
        end
        message = EMPTY_BLK;
        apply_reset(1);
        run_to_ready("reset_mid", EMPTY_DIG, -1, 512'd0);
    endtask

    task automatic test_random();
        logic [511:0] blk;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = $urandom;
            apply_reset(1);
            message = blk;
            run_to_ready("random", sha256_ref(blk), -1, 512'd0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        message = ABC_BLK;
        test_reset();
        test_abc();
        test_stability();
        test_empty();
        test_msg_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
